// File: rtl/pc_unit.sv
// Program-counter unit: boot delay, handshake/stall-gated increment, redirect/trap override,
// halt/resume and misaligned-target detection. Optional PC history buffer under PC_HISTORY_EN.
module pc_unit #(
  parameter int unsigned     XLEN         = 64,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int unsigned     INC          = 4,
  parameter int unsigned     ALIGN_BITS   = 2,
  parameter int unsigned     BOOT_DELAY   = 2
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_stall,
  input  logic            i_fetch_ready,
  input  logic            i_redirect_valid,
  input  logic [XLEN-1:0] i_redirect_target,
  input  logic            i_trap_valid,
  input  logic [XLEN-1:0] i_trap_vector,
  input  logic            i_halt_req,
  input  logic            i_resume,
`ifdef PC_HISTORY_EN
  input  logic [2:0]      i_hist_idx,
  output logic [XLEN-1:0] o_hist_pc,
`endif
  output logic [XLEN-1:0] o_pc_out,
  output logic            o_pc_valid,
  output logic            o_misaligned_err,
  output logic [XLEN-1:0] o_misaligned_addr,
  output logic [1:0]      o_state_out
);

  localparam int unsigned CW = (BOOT_DELAY > 1) ? $clog2(BOOT_DELAY) : 1;
  localparam logic [XLEN-1:0] ALIGN_MASK = ~({XLEN{1'b1}} << ALIGN_BITS);

  typedef enum logic [1:0] {
    StBoot = 2'd0,
    StRun  = 2'd1,
    StHalt = 2'd2
  } state_t;

  state_t          r_state, w_state_d;
  logic [XLEN-1:0] r_pc, w_pc_d;
  logic [CW-1:0]   r_cnt, w_cnt_d;
  logic            r_err, w_err_d;
  logic [XLEN-1:0] r_addr, w_addr_d;
  logic            w_hist_we;
  logic            w_misaligned;

  assign w_misaligned = |(i_redirect_target & ALIGN_MASK);

  always_comb begin
    w_state_d = r_state;
    w_pc_d    = r_pc;
    w_cnt_d   = r_cnt;
    w_err_d   = 1'b0;
    w_addr_d  = r_addr;
    w_hist_we = 1'b0;
    unique case (r_state)
      StBoot: begin
        if (r_cnt == CW'(BOOT_DELAY - 1)) begin
          w_state_d = StRun;
          w_cnt_d   = '0;
        end else begin
          w_cnt_d = r_cnt + CW'(1);
        end
      end
      StRun: begin
        if (i_trap_valid) begin
          w_pc_d    = i_trap_vector;
          w_hist_we = 1'b1;
        end else if (i_redirect_valid && !w_misaligned) begin
          w_pc_d    = i_redirect_target;
          w_hist_we = 1'b1;
        end else if (i_redirect_valid) begin
          // Misaligned target diverts to the trap handler and flags the offender.
          w_pc_d    = i_trap_vector;
          w_err_d   = 1'b1;
          w_addr_d  = i_redirect_target;
          w_hist_we = 1'b1;
        end else if (i_halt_req) begin
          w_state_d = StHalt;
        end else if (!i_stall && i_fetch_ready) begin
          w_pc_d = r_pc + XLEN'(INC);
        end
      end
      StHalt: begin
        if (i_trap_valid) begin
          w_pc_d    = i_trap_vector;
          w_state_d = StRun;
          w_hist_we = 1'b1;
        end else if (i_resume) begin
          w_state_d = StRun;
        end
      end
      default: w_state_d = StBoot;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= StBoot;
      r_pc    <= RESET_VECTOR;
      r_cnt   <= '0;
      r_err   <= 1'b0;
      r_addr  <= '0;
    end else begin
      r_state <= w_state_d;
      r_pc    <= w_pc_d;
      r_cnt   <= w_cnt_d;
      r_err   <= w_err_d;
      r_addr  <= w_addr_d;
    end
  end

`ifdef PC_HISTORY_EN
  logic [XLEN-1:0] r_hist [8];
  logic [2:0]      r_wr_ptr;

  // Records the PC being left at each taken redirect or trap.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < 8; i++) r_hist[i] <= '0;
      r_wr_ptr <= '0;
    end else if (w_hist_we) begin
      r_hist[r_wr_ptr] <= r_pc;
      r_wr_ptr         <= r_wr_ptr + 3'd1;
    end
  end

  assign o_hist_pc = r_hist[r_wr_ptr - 3'd1 - i_hist_idx];
`else
  logic w_unused_hist_we;
  assign w_unused_hist_we = w_hist_we;
`endif

  assign o_pc_out          = r_pc;
  assign o_pc_valid        = (r_state == StRun);
  assign o_misaligned_err  = r_err;
  assign o_misaligned_addr = r_addr;
  assign o_state_out       = r_state;

endmodule

// File: tb/tb_pc_unit.sv
// Directed self-checking bench for pc_unit (RESET_VECTOR=0x1000, BOOT_DELAY=2, INC=4).
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, fetch_ready, redirect_valid, trap_valid, halt_req, resume;
  logic [63:0] redirect_target, trap_vector;
  logic [63:0] pc_out, misaligned_addr;
  logic        pc_valid, misaligned_err;
  logic [1:0]  state_out;

  int n_tests = 0;
  int n_fail  = 0;

  pc_unit #(
    .XLEN        (64),
    .RESET_VECTOR(64'h1000),
    .INC         (4),
    .ALIGN_BITS  (2),
    .BOOT_DELAY  (2)
  ) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_stall          (stall),
    .i_fetch_ready    (fetch_ready),
    .i_redirect_valid (redirect_valid),
    .i_redirect_target(redirect_target),
    .i_trap_valid     (trap_valid),
    .i_trap_vector    (trap_vector),
    .i_halt_req       (halt_req),
    .i_resume         (resume),
    .o_pc_out         (pc_out),
    .o_pc_valid       (pc_valid),
    .o_misaligned_err (misaligned_err),
    .o_misaligned_addr(misaligned_addr),
    .o_state_out      (state_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; fetch_ready = 1'b1; redirect_valid = 1'b0; trap_valid = 1'b0;
    halt_req = 1'b0; resume = 1'b0; redirect_target = '0; trap_vector = '0;
    repeat (2) tick();
    n_tests++;
    if (pc_out !== 64'h1000 || pc_valid !== 1'b0 || state_out !== 2'd0 ||
        misaligned_err !== 1'b0 || misaligned_addr !== 64'h0) begin
      $display("FAIL reset_state: pc=%h valid=%b st=%0d err=%b addr=%h, want 1000/0/0/0/0",
               pc_out, pc_valid, state_out, misaligned_err, misaligned_addr);
      n_fail++;
    end
    // Redirect/trap/halt asserted during BOOT must be ignored.
    redirect_valid = 1'b1; redirect_target = 64'h5000;
    trap_valid = 1'b1; trap_vector = 64'h80; halt_req = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_tests++;
    if (pc_valid !== 1'b0 || pc_out !== 64'h1000) begin
      $display("FAIL boot_cycle1: valid=%b pc=%h, want 0/1000", pc_valid, pc_out);
      n_fail++;
    end
    tick();
    n_tests++;
    if (pc_valid !== 1'b0 || pc_out !== 64'h1000 || state_out !== 2'd0) begin
      $display("FAIL boot_cycle2: valid=%b pc=%h st=%0d, want 0/1000/0",
               pc_valid, pc_out, state_out);
      n_fail++;
    end
    tick();
    redirect_valid = 1'b0; trap_valid = 1'b0; halt_req = 1'b0;
    n_tests++;
    if (pc_valid !== 1'b1 || pc_out !== 64'h1000 || state_out !== 2'd1) begin
      $display("FAIL boot_cycle3: valid=%b pc=%h st=%0d, want 1/1000/1",
               pc_valid, pc_out, state_out);
      n_fail++;
    end
    tick();
    n_tests++;
    if (pc_out !== 64'h1004) begin
      $display("FAIL boot_cycle4: pc=%h, want 1004", pc_out);
      n_fail++;
    end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if (pc_out !== 64'h1004) begin
        $display("FAIL stall_hold[%0d]: pc=%h, want 1004", i, pc_out);
        n_fail++;
      end
    end
    stall = 1'b0;
    tick();
    n_tests++;
    if (pc_out !== 64'h1008) begin
      $display("FAIL stall_release: pc=%h, want 1008", pc_out);
      n_fail++;
    end
    fetch_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if (pc_out !== 64'h1008) begin
        $display("FAIL notready_hold[%0d]: pc=%h, want 1008", i, pc_out);
        n_fail++;
      end
    end
    fetch_ready = 1'b1;
    tick();
    n_tests++;
    if (pc_out !== 64'h100c) begin
      $display("FAIL ready_release: pc=%h, want 100c", pc_out);
      n_fail++;
    end
  endtask

  task automatic test_redirect();
    stall = 1'b1;
    redirect_valid = 1'b1; redirect_target = 64'h2000;
    tick();
    n_tests++;
    if (pc_out !== 64'h2000) begin
      $display("FAIL redirect_over_stall: pc=%h, want 2000", pc_out);
      n_fail++;
    end
    trap_valid = 1'b1; trap_vector = 64'h80; redirect_target = 64'h3000;
    tick();
    trap_valid = 1'b0; redirect_valid = 1'b0;
    n_tests++;
    if (pc_out !== 64'h80 || misaligned_err !== 1'b0) begin
      $display("FAIL trap_over_redirect: pc=%h err=%b, want 80/0", pc_out, misaligned_err);
      n_fail++;
    end
  endtask

  task automatic test_misaligned();
    redirect_valid = 1'b1; redirect_target = 64'h3000;
    tick();
    redirect_target = 64'h2002; trap_vector = 64'h80;
    tick();
    redirect_valid = 1'b0;
    n_tests++;
    if (pc_out !== 64'h80 || misaligned_err !== 1'b1 || misaligned_addr !== 64'h2002) begin
      $display("FAIL misaligned_hit: pc=%h err=%b addr=%h, want 80/1/2002",
               pc_out, misaligned_err, misaligned_addr);
      n_fail++;
    end
    tick();
    n_tests++;
    if (misaligned_err !== 1'b0 || misaligned_addr !== 64'h2002 || pc_out !== 64'h80) begin
      $display("FAIL misaligned_pulse_end: err=%b addr=%h pc=%h, want 0/2002/80",
               misaligned_err, misaligned_addr, pc_out);
      n_fail++;
    end
    // Back-to-back misaligned redirects keep the flag high on both cycles.
    redirect_valid = 1'b1; redirect_target = 64'h2001; trap_vector = 64'h180;
    tick();
    redirect_target = 64'h3003;
    n_tests++;
    if (misaligned_err !== 1'b1 || misaligned_addr !== 64'h2001 || pc_out !== 64'h180) begin
      $display("FAIL b2b_first: err=%b addr=%h pc=%h, want 1/2001/180",
               misaligned_err, misaligned_addr, pc_out);
      n_fail++;
    end
    tick();
    redirect_valid = 1'b0;
    n_tests++;
    if (misaligned_err !== 1'b1 || misaligned_addr !== 64'h3003) begin
      $display("FAIL b2b_second: err=%b addr=%h, want 1/3003", misaligned_err, misaligned_addr);
      n_fail++;
    end
    tick();
    n_tests++;
    if (misaligned_err !== 1'b0) begin
      $display("FAIL b2b_end: err=%b, want 0", misaligned_err);
      n_fail++;
    end
    stall = 1'b0;
  endtask

  task automatic test_halt();
    // PC is 0x180, stall released, fetch_ready high.
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    n_tests++;
    if (state_out !== 2'd2 || pc_valid !== 1'b0 || pc_out !== 64'h180) begin
      $display("FAIL halt_enter: st=%0d valid=%b pc=%h, want 2/0/180",
               state_out, pc_valid, pc_out);
      n_fail++;
    end
    redirect_valid = 1'b1; redirect_target = 64'h7000;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_tests++;
      if (pc_out !== 64'h180 || pc_valid !== 1'b0) begin
        $display("FAIL halt_frozen[%0d]: pc=%h valid=%b, want 180/0", i, pc_out, pc_valid);
        n_fail++;
      end
    end
    redirect_valid = 1'b0;
    resume = 1'b1;
    tick();
    resume = 1'b0;
    n_tests++;
    if (pc_valid !== 1'b1 || state_out !== 2'd1 || pc_out !== 64'h180) begin
      $display("FAIL resume: valid=%b st=%0d pc=%h, want 1/1/180", pc_valid, state_out, pc_out);
      n_fail++;
    end
    tick();
    n_tests++;
    if (pc_out !== 64'h184) begin
      $display("FAIL resume_increment: pc=%h, want 184", pc_out);
      n_fail++;
    end
    // Redirect wins over a simultaneous halt request; halt follows next cycle.
    halt_req = 1'b1; redirect_valid = 1'b1; redirect_target = 64'h4000;
    tick();
    redirect_valid = 1'b0;
    n_tests++;
    if (pc_out !== 64'h4000 || state_out !== 2'd1) begin
      $display("FAIL halt_with_redirect: pc=%h st=%0d, want 4000/1", pc_out, state_out);
      n_fail++;
    end
    tick();
    halt_req = 1'b0;
    n_tests++;
    if (state_out !== 2'd2 || pc_out !== 64'h4000) begin
      $display("FAIL halt_after_redirect: st=%0d pc=%h, want 2/4000", state_out, pc_out);
      n_fail++;
    end
    trap_valid = 1'b1; trap_vector = 64'h100;
    tick();
    trap_valid = 1'b0;
    n_tests++;
    if (pc_out !== 64'h100 || state_out !== 2'd1 || pc_valid !== 1'b1) begin
      $display("FAIL trap_wake: pc=%h st=%0d valid=%b, want 100/1/1",
               pc_out, state_out, pc_valid);
      n_fail++;
    end
  endtask

  task automatic test_wrap();
    redirect_valid = 1'b1; redirect_target = 64'hffff_ffff_ffff_fff8;
    tick();
    redirect_valid = 1'b0;
    tick();
    n_tests++;
    if (pc_out !== 64'hffff_ffff_ffff_fffc) begin
      $display("FAIL wrap_pre: pc=%h, want fffffffffffffffc", pc_out);
      n_fail++;
    end
    tick();
    n_tests++;
    if (pc_out !== 64'h0) begin
      $display("FAIL wrap_zero: pc=%h, want 0", pc_out);
      n_fail++;
    end
    tick();
    n_tests++;
    if (pc_out !== 64'h4) begin
      $display("FAIL wrap_after: pc=%h, want 4", pc_out);
      n_fail++;
    end
  endtask

  task automatic test_reset_mid();
    redirect_valid = 1'b1; redirect_target = 64'h6006; trap_vector = 64'h200;
    tick();
    redirect_valid = 1'b0;
    n_tests++;
    if (misaligned_err !== 1'b1 || pc_out !== 64'h200) begin
      $display("FAIL pre_reset_err: err=%b pc=%h, want 1/200", misaligned_err, pc_out);
      n_fail++;
    end
    #2;
    rst = 1'b1;
    #1;
    n_tests++;
    if (pc_out !== 64'h1000 || pc_valid !== 1'b0 || state_out !== 2'd0 ||
        misaligned_err !== 1'b0 || misaligned_addr !== 64'h0) begin
      $display("FAIL async_reset: pc=%h valid=%b st=%0d err=%b addr=%h, want 1000/0/0/0/0",
               pc_out, pc_valid, state_out, misaligned_err, misaligned_addr);
      n_fail++;
    end
    tick();
    @(negedge clk);
    rst = 1'b0;
    repeat (3) tick();
    n_tests++;
    if (pc_valid !== 1'b1 || pc_out !== 64'h1004) begin
      $display("FAIL reboot: valid=%b pc=%h, want 1/1004", pc_valid, pc_out);
      n_fail++;
    end
  endtask

  initial begin
    test_reset();
    test_stall();
    test_redirect();
    test_misaligned();
    test_halt();
    test_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
